// File: rtl/zeroriscy_instr_bus_arbiter_if.sv
// Pipelined req/gnt/rvalid instruction-bus channel used on both the master and memory sides.
interface zeroriscy_instr_bus_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/zeroriscy_instr_bus_arbiter.sv
// Two-master instruction-port arbiter: round-robin (or fixed) selection locked while a request
// waits for grant, with an in-order owner FIFO steering each response back to its requester.
module zeroriscy_instr_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          FIXED_PRIO      = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  zeroriscy_instr_bus_arbiter_if.slave        m0_if,
  zeroriscy_instr_bus_arbiter_if.slave        m1_if,
  zeroriscy_instr_bus_arbiter_if.master       instr_if,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  localparam logic StArb  = 1'b0;
  localparam logic StHold = 1'b1;

  logic                       state_q, state_d;
  logic                       sel_q, sel_d;
  logic                       last_q, last_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       err_q, err_d;

  logic arb_sel, sel, sel_req, room, hs, pop, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    if (m0_if.req && m1_if.req) begin
      arb_sel = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      arb_sel = m1_if.req;
    end
  end

  // In HOLD the latched owner is kept even if the other master requests meanwhile.
  assign sel      = (state_q == StHold) ? sel_q : arb_sel;
  assign sel_req  = sel ? m1_if.req : m0_if.req;
  assign room     = (count_q < MaxCnt);
  assign hs       = instr_if.req & instr_if.gnt;
  assign pop      = instr_if.rvalid & (count_q != '0);
  assign head     = owner_q[rd_ptr_q];

  assign instr_if.req  = sel_req & room;
  assign instr_if.addr = sel ? m1_if.addr : m0_if.addr;

  assign m0_if.gnt    = hs & ~sel;
  assign m1_if.gnt    = hs & sel;
  assign m0_if.rvalid = pop & ~head;
  assign m1_if.rvalid = pop & head;
  assign m0_if.rdata  = instr_if.rdata;
  assign m1_if.rdata  = instr_if.rdata;

  assign busy_o = (count_q != '0) | (state_q == StHold);
  assign err_o  = err_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (instr_if.rvalid & (count_q == '0));

    if (state_q == StArb) begin
      if (instr_if.req && !instr_if.gnt) begin
        state_d = StHold;
        sel_d   = sel;
      end
    end else if (hs || !sel_req) begin
      state_d = StArb;
    end

    if (hs) begin
      owner_d[wr_ptr_q] = sel;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      last_d            = sel;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (hs && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!hs && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StArb;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_zeroriscy_instr_bus_arbiter.sv
// Directed bench for the instruction-bus arbiter; expected owners are queued at grant time and
// consumed as the bench returns responses.
module tb_zeroriscy_instr_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, err, fp_busy, fp_err;

  always #5 clk = ~clk;

  zeroriscy_instr_bus_arbiter_if m0_if ();
  zeroriscy_instr_bus_arbiter_if m1_if ();
  zeroriscy_instr_bus_arbiter_if mem_if ();
  zeroriscy_instr_bus_arbiter_if fp_m0 ();
  zeroriscy_instr_bus_arbiter_if fp_m1 ();
  zeroriscy_instr_bus_arbiter_if fp_mem ();

  // Fixed-priority instance sees the same master and memory stimulus.
  assign fp_m0.req     = m0_if.req;
  assign fp_m0.addr    = m0_if.addr;
  assign fp_m1.req     = m1_if.req;
  assign fp_m1.addr    = m1_if.addr;
  assign fp_mem.gnt    = mem_if.gnt;
  assign fp_mem.rvalid = mem_if.rvalid;
  assign fp_mem.rdata  = mem_if.rdata;

  zeroriscy_instr_bus_arbiter #(
    .MAX_OUTSTANDING(2),
    .FIXED_PRIO     (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0_if   (m0_if),
    .m1_if   (m1_if),
    .instr_if(mem_if),
    .busy_o  (busy),
    .err_o   (err)
  );

  zeroriscy_instr_bus_arbiter #(
    .MAX_OUTSTANDING(2),
    .FIXED_PRIO     (1'b1)
  ) dut_fp (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0_if   (fp_m0),
    .m1_if   (fp_m1),
    .instr_if(fp_mem),
    .busy_o  (fp_busy),
    .err_o   (fp_err)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                       input bit g, input bit rv, input logic [31:0] rd);
    m0_if.req     = r0;
    m0_if.addr    = a0;
    m1_if.req     = r1;
    m1_if.addr    = a1;
    mem_if.gnt    = g;
    mem_if.rvalid = rv;
    mem_if.rdata  = rd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // exp_owner < 0 means no grant may be given this cycle.
  task automatic chk_gnt(input string tag, input int exp_owner, input logic [31:0] exp_addr);
    if (exp_owner < 0) begin
      chk({tag, "_m0_gnt"}, 32'(m0_if.gnt), 0);
      chk({tag, "_m1_gnt"}, 32'(m1_if.gnt), 0);
    end else begin
      chk({tag, "_req"}, 32'(mem_if.req), 1);
      chk({tag, "_addr"}, mem_if.addr, exp_addr);
      chk({tag, "_m0_gnt"}, 32'(m0_if.gnt), 32'(exp_owner == 0));
      chk({tag, "_m1_gnt"}, 32'(m1_if.gnt), 32'(exp_owner == 1));
      exp_q.push_back(exp_owner == 1);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] data);
    bit o;
    o = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      o = exp_q.pop_front();
    end
    chk({tag, "_m0_rvalid"}, 32'(m0_if.rvalid), 32'(!o));
    chk({tag, "_m1_rvalid"}, 32'(m1_if.rvalid), 32'(o));
    chk({tag, "_rdata"}, o ? m1_if.rdata : m0_if.rdata, data);
  endtask

  task automatic resp_only(input string tag, input logic [31:0] data);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, data);
    settle();
    chk_resp(tag, data);
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    settle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(mem_if.req), 0);
    chk("rst_gnt", 32'({m0_if.gnt, m1_if.gnt}), 0);
    chk("rst_rvalid", 32'({m0_if.rvalid, m1_if.rvalid}), 0);
    tick();
    rst_n = 1'b1;

    // Single-master fetch
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("t1_c0", 0, 32'h80);
    chk("t1_busy0", 32'(busy), 0);
    tick();
    idle();
    settle();
    chk("t1_busy1", 32'(busy), 1);
    chk("t1_rv_early", 32'({m0_if.rvalid, m1_if.rvalid}), 0);
    tick();
    resp_only("t1_c2", 32'h00000013);
    settle();
    chk("t1_busy_end", 32'(busy), 0);
    tick();

    // Round-robin alternation; fixed-priority instance must always pick m0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, k > 0, 32'(k));
      settle();
      if (k > 0) chk_resp("rr_resp", 32'(k));
      chk_gnt("rr_gnt", k % 2, (k % 2 == 1) ? 32'h200 : 32'h100);
      chk("fp_m0_gnt", 32'(fp_m0.gnt), 1);
      chk("fp_m1_gnt", 32'(fp_m1.gnt), 0);
      chk("fp_m0_rvalid", 32'(fp_m0.rvalid), 32'(k > 0));
      tick();
    end
    resp_only("rr_drain", 32'd6);

    // HOLD lock: m1 waits without grant while m0 starts requesting
    drive(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
    settle();
    chk("hold_addr0", mem_if.addr, 32'h1000);
    chk_gnt("hold_c0", -1, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h80, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
      settle();
      chk("hold_addr", mem_if.addr, 32'h1000);
      chk_gnt("hold_wait", -1, 32'h0);
      chk("hold_busy", 32'(busy), 1);
      tick();
    end
    drive(1'b1, 32'h80, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("hold_m1", 1, 32'h1000);
    tick();
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("hold_m0", 0, 32'h80);
    tick();
    resp_only("hold_r1", 32'h000000A1);
    resp_only("hold_r2", 32'h000000B2);

    // Outstanding limit
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      settle();
      chk_gnt("lim_g", 0, 32'h300 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h308, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("lim_req_full", 32'(mem_if.req), 0);
    chk_gnt("lim_full", -1, 32'h0);
    tick();
    drive(1'b1, 32'h308, 1'b0, 32'h0, 1'b1, 1'b1, 32'h000000C0);
    settle();
    chk_resp("lim_pop", 32'h000000C0);
    chk("lim_req_nobypass", 32'(mem_if.req), 0);
    chk_gnt("lim_nobypass", -1, 32'h0);
    tick();
    drive(1'b1, 32'h308, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("lim_third", 0, 32'h308);
    tick();
    resp_only("lim_r1", 32'h000000C1);
    resp_only("lim_r2", 32'h000000C2);

    // Mixed routing with simultaneous response and grant
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("mix_g0", 0, 32'h80);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("mix_g1", 1, 32'h2000);
    tick();
    resp_only("mix_ra", 32'hAAAA0000);
    drive(1'b1, 32'h84, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB1111);
    settle();
    chk_resp("mix_rb", 32'hBBBB1111);
    chk_gnt("mix_g2", 0, 32'h84);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h2004, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("mix_g3", 1, 32'h2004);
    tick();
    drive(1'b1, 32'h88, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("mix_full_req", 32'(mem_if.req), 0);
    tick();
    resp_only("mix_rc", 32'hCCCC2222);
    resp_only("mix_rd", 32'hDDDD3333);

    // Response with empty FIFO, then asynchronous reset mid-transaction
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000DEAD);
    settle();
    chk("err_no_rv", 32'({m0_if.rvalid, m1_if.rvalid}), 0);
    chk("err_not_yet", 32'(err), 0);
    tick();
    idle();
    settle();
    chk("err_set", 32'(err), 1);
    tick();
    tick();
    settle();
    chk("err_sticky", 32'(err), 1);
    tick();
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    settle();
    chk_gnt("rst_mid_g", 0, 32'h80);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_err", 32'(err), 0);
    exp_q.delete();
    idle();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000042);
    settle();
    chk("late_no_rv", 32'({m0_if.rvalid, m1_if.rvalid}), 0);
    tick();
    idle();
    settle();
    chk("late_err", 32'(err), 1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
